lift_seq: RTL and testbench

- Row sequencer that sits directly upstream of lift_step.
- Buffers one row of 8-bit samples and runs a full 1-D lifting pass over it: a predict pass over odd indices, then an update pass over even indices.
- For each index it drives a left/sam/right triple with flags and a one-cycle update strobe into lift_step, waits for update_o, and writes res_o back into the row buffer.
- Applies JPEG-2000 symmetric extension at both row boundaries.

---
 rtl/lift_seq.sv | 158 +++++++++++++++
 tb/tb_lift_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lift_seq.sv
// Row sequencer for lift_step: buffers one row, issues a predict pass (odd indices) then an update pass (even indices)
// with symmetric boundary extension. Define LIFT_SEQ_INVERSE_EN to add inv_i and the reversed inverse ordering.
module lift_seq #(
    parameter int W  = 8,
    parameter int N  = 64,
    parameter int AW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          start_i,
`ifdef LIFT_SEQ_INVERSE_EN
    input  logic          inv_i,
`endif
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o,
    output logic [W-1:0]  left_o,
    output logic [W-1:0]  sam_o,
    output logic [W-1:0]  right_o,
    output logic [2:0]    flags_o,
    output logic          upd_o,
    input  logic [W:0]    res_i,
    input  logic          res_valid_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [2:0]    state_o
);

    // Handshake: upd_o is a one-cycle request with operands held stable until
    // res_valid_i is seen in a WAIT state; res_valid_i anywhere else is dropped.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_ISSUE = 3'd1,
        P_WAIT  = 3'd2,
        U_ISSUE = 3'd3,
        U_WAIT  = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic [AW-1:0] PEN  = AW'(N - 2);

    state_t        state, state_d;
    logic [AW-1:0] idx, idx_d;
    logic [AW-1:0] lidx, ridx;
    logic          inv_q, inv_start;
    logic [W-1:0]  mem [N];
    logic          res_sign_unused;

    assign res_sign_unused = res_i[W];

`ifdef LIFT_SEQ_INVERSE_EN
    assign inv_start = inv_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            inv_q <= 1'b0;
        else if (state == IDLE && start_i)
            inv_q <= inv_i;
    end
`else
    assign inv_start = 1'b0;
    assign inv_q     = 1'b0;
`endif

    // Mirror at both ends: x[-1] -> x[1], x[N] -> x[N-2].
    assign lidx = (idx == '0)   ? AW'(1) : idx - AW'(1);
    assign ridx = (idx == LAST) ? PEN    : idx + AW'(1);

    always_comb begin
        state_d = state;
        idx_d   = idx;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_d = inv_start ? U_ISSUE : P_ISSUE;
                    idx_d   = inv_start ? AW'(0) : AW'(1);
                end
            end
            P_ISSUE: state_d = P_WAIT;
            U_ISSUE: state_d = U_WAIT;
            P_WAIT: begin
                if (res_valid_i) begin
                    if (idx == LAST) begin
                        state_d = inv_q ? FIN : U_ISSUE;
                        idx_d   = AW'(0);
                    end else begin
                        state_d = P_ISSUE;
                        idx_d   = idx + AW'(2);
                    end
                end
            end
            U_WAIT: begin
                if (res_valid_i) begin
                    if (idx == PEN) begin
                        state_d = inv_q ? P_ISSUE : FIN;
                        idx_d   = AW'(1);
                    end else begin
                        state_d = U_ISSUE;
                        idx_d   = idx + AW'(2);
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            left_o  <= '0;
            sam_o   <= '0;
            right_o <= '0;
            flags_o <= '0;
            upd_o   <= 1'b0;
        end else begin
            upd_o <= 1'b0;
            if (state == P_ISSUE || state == U_ISSUE) begin
                left_o  <= mem[lidx];
                sam_o   <= mem[idx];
                right_o <= mem[ridx];
                flags_o <= {1'b1, inv_q, state == P_ISSUE};
                upd_o   <= 1'b1;
            end
        end
    end

    // Row buffer is deliberately not reset; external writes only land while idle.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && wr_en_i)
            mem[wr_addr_i] <= wr_data_i;
        else if ((state == P_WAIT || state == U_WAIT) && res_valid_i)
            mem[idx] <= res_i[W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            rd_data_o <= '0;
        else
            rd_data_o <= mem[rd_addr_i];
    end

    assign busy_o  = (state != IDLE) && (state != FIN);
    assign done_o  = (state == FIN);
    assign state_o = state;

endmodule

// File: tb/tb_lift_seq.sv
// Bench for lift_seq (N=4): table of rows with stub lift_step results and hand-computed issue operands,
// plus directed sequences for reset mid-pass, writes/start while busy and a stray res_valid_i.
module tb_lift_seq;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    logic [W-1:0]  wr_data_i;
    logic          start_i;
    logic          inv_i;
    logic [AW-1:0] rd_addr_i;
    logic [W-1:0]  rd_data_o, left_o, sam_o, right_o;
    logic [2:0]    flags_o, state;
    logic          upd_o, res_valid_i, busy_o, done_o;
    logic [W:0]    res_i;

    int tests = 0;
    int fails = 0;
    int upd_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    lift_seq #(.W(W), .N(N), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .start_i(start_i),
`ifdef LIFT_SEQ_INVERSE_EN
        .inv_i(inv_i),
`endif
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .left_o(left_o), .sam_o(sam_o),
        .right_o(right_o), .flags_o(flags_o), .upd_o(upd_o), .res_i(res_i),
        .res_valid_i(res_valid_i), .busy_o(busy_o), .done_o(done_o), .state_o(state)
    );

    always @(negedge clk) begin
        if (upd_o) upd_cnt++;
        if (done_o) done_cnt++;
    end

    typedef struct {
        logic [3:0][W-1:0] x;
        logic [3:0][W:0]   r;
        logic [3:0][W-1:0] el, es, er;
        logic [3:0][2:0]   ef;
        logic [3:0][W-1:0] fin;
        int                lat;
        bit                inv;
        bit                poke;
    } vec_t;

    vec_t vecs[5];
    int   nv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads x[0..2], then writes x[3] in the same cycle as start_i.
    task automatic load_and_start(input vec_t v);
        for (int a = 0; a < 4; a++) begin
            wr_en_i   = 1'b1;
            wr_addr_i = AW'(a);
            wr_data_i = v.x[a];
            start_i   = (a == 3);
            inv_i     = v.inv;
            tick();
        end
        wr_en_i = 1'b0;
        start_i = 1'b0;
        inv_i   = 1'b0;
    endtask

    task automatic wait_upd(input string name);
        int n = 0;
        while (!upd_o && n < 50) begin
            tick();
            n++;
        end
        if (!upd_o) begin
            tests++;
            fails++;
            $display("FAIL %s timeout waiting for upd_o", name);
        end
    endtask

    task automatic read_word(input int a, output logic [W-1:0] d);
        rd_addr_i = AW'(a);
        tick();
        d = rd_data_o;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          u0, d0;
        logic [W-1:0] d;
        u0 = upd_cnt;
        d0 = done_cnt;
        load_and_start(v);
        check($sformatf("v%0d busy_after_start", id), busy_o, 1);
        for (int k = 0; k < 4; k++) begin
            wait_upd($sformatf("v%0d step%0d", id, k));
            check($sformatf("v%0d s%0d left", id, k), left_o, v.el[k]);
            check($sformatf("v%0d s%0d sam", id, k), sam_o, v.es[k]);
            check($sformatf("v%0d s%0d right", id, k), right_o, v.er[k]);
            check($sformatf("v%0d s%0d flags", id, k), flags_o, v.ef[k]);
            if (v.poke && k == 0) begin
                wr_en_i   = 1'b1;
                wr_addr_i = '0;
                wr_data_i = 8'h55;
                start_i   = 1'b1;
                tick();
                wr_en_i = 1'b0;
                start_i = 1'b0;
                repeat (v.lat - 1) tick();
            end else begin
                repeat (v.lat) tick();
            end
            res_valid_i = 1'b1;
            res_i       = v.r[k];
            tick();
            if (v.poke && k == 0) begin
                // now in the next ISSUE state: this pulse must be ignored
                res_i = 9'h033;
                tick();
            end
            res_valid_i = 1'b0;
            res_i       = '0;
        end
        check($sformatf("v%0d done_pulse", id), done_o, 1);
        check($sformatf("v%0d busy_at_done", id), busy_o, 0);
        tick();
        check($sformatf("v%0d done_cleared", id), done_o, 0);
        check($sformatf("v%0d state_idle", id), state, 0);
        check($sformatf("v%0d upd_count", id), upd_cnt - u0, 4);
        check($sformatf("v%0d done_count", id), done_cnt - d0, 1);
        for (int a = 0; a < 4; a++) begin
            read_word(a, d);
            check($sformatf("v%0d row[%0d]", id, a), d, v.fin[a]);
        end
    endtask

    initial begin
        logic [W-1:0] d;
        int d0;
        rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; start_i = 1'b0;
        inv_i = 1'b0; rd_addr_i = '0; res_i = '0; res_valid_i = 1'b0;

        // Rows list x[3] first in each concatenation; step order is i=1,3,0,2 (forward).
        vecs[0] = '{x: {8'd250, 8'd163, 8'd218, 8'd68}, r: {9'h100, 9'd10, 9'd100, 9'h1FD},
                    el: {8'd253, 8'd253, 8'd163, 8'd68}, es: {8'd163, 8'd68, 8'd250, 8'd218},
                    er: {8'd100, 8'd253, 8'd163, 8'd163}, ef: {3'd4, 3'd4, 3'd5, 3'd5},
                    fin: {8'd100, 8'd0, 8'd253, 8'd10}, lat: 1, inv: 1'b0, poke: 1'b0};
        vecs[1] = '{x: {8'd128, 8'd1, 8'd255, 8'd0}, r: {9'h0AA, 9'd77, 9'h1FF, 9'd5},
                    el: {8'd5, 8'd5, 8'd1, 8'd0}, es: {8'd1, 8'd0, 8'd128, 8'd255},
                    er: {8'd255, 8'd5, 8'd1, 8'd1}, ef: {3'd4, 3'd4, 3'd5, 3'd5},
                    fin: {8'd255, 8'd170, 8'd5, 8'd77}, lat: 3, inv: 1'b0, poke: 1'b0};
        vecs[2] = '{x: {8'd4, 8'd3, 8'd2, 8'd1}, r: {9'h1FE, 9'd0, 9'd7, 9'h180},
                    el: {8'd128, 8'd128, 8'd3, 8'd1}, es: {8'd3, 8'd1, 8'd4, 8'd2},
                    er: {8'd7, 8'd128, 8'd3, 8'd3}, ef: {3'd4, 3'd4, 3'd5, 3'd5},
                    fin: {8'd7, 8'd254, 8'd128, 8'd0}, lat: 0, inv: 1'b0, poke: 1'b0};
        vecs[3] = vecs[0];
        vecs[3].lat  = 2;
        vecs[3].poke = 1'b1;
        nv = 4;
`ifdef LIFT_SEQ_INVERSE_EN
        // Inverse order: i=0,2 (flags 6) then i=1,3 (flags 7).
        vecs[4] = '{x: {8'd250, 8'd163, 8'd218, 8'd68}, r: {9'h100, 9'd10, 9'd100, 9'h1FD},
                    el: {8'd100, 8'd253, 8'd218, 8'd218}, es: {8'd250, 8'd218, 8'd163, 8'd68},
                    er: {8'd100, 8'd100, 8'd250, 8'd218}, ef: {3'd7, 3'd7, 3'd6, 3'd6},
                    fin: {8'd0, 8'd100, 8'd10, 8'd253}, lat: 1, inv: 1'b1, poke: 1'b0};
        nv = 5;
`endif

        repeat (2) tick();
        check("rst busy", busy_o, 0);
        check("rst done", done_o, 0);
        check("rst upd", upd_o, 0);
        check("rst flags", flags_o, 0);
        check("rst operands", {left_o, sam_o, right_o}, 0);
        check("rst rd_data", rd_data_o, 0);
        check("rst state", state, 0);
        rst_i = 1'b0;
        tick();

        // Reset asserted while waiting for the first result.
        d0 = done_cnt;
        load_and_start(vecs[0]);
        wait_upd("midrst");
        check("midrst flags_before", flags_o, 5);
        rst_i = 1'b1;
        #1;
        check("midrst busy", busy_o, 0);
        check("midrst upd", upd_o, 0);
        check("midrst flags", flags_o, 0);
        tick();
        rst_i = 1'b0;
        repeat (3) tick();
        check("midrst no_done", done_cnt - d0, 0);
        check("midrst idle", state, 0);
        read_word(1, d);
        check("midrst row_kept", d, 218);

        for (int v = 0; v < nv; v++) run_vec(v, vecs[v]);

        // Stray result while idle must not touch the buffer.
        res_valid_i = 1'b1;
        res_i       = 9'h0EE;
        tick();
        res_valid_i = 1'b0;
        for (int a = 0; a < 4; a++) begin
            read_word(a, d);
            check($sformatf("idle_stray row[%0d]", a), d, vecs[nv-1].fin[a]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
